// File: rtl/fir_mac_mc.sv
// Multi-channel FIR: one serial MAC time-shared over NUM_CH circular delay lines
// that share a coefficient bank; round-half-up scaling with output saturation.
//
// state | meaning
// IDLE  | ready for a sample, coefficient write or flush
// MAC   | one tap product per cycle, k = 0..NUM_TAPS-1
// OUT   | rounded/saturated result on dout, valid_out strobe
module fir_mac_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 64,
    parameter int NUM_CH   = 2,
    parameter int SHIFT    = 21,
    localparam int AW      = $clog2(NUM_TAPS),
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ACC_W   = DATA_W + COEF_W + AW
) (
    input  logic                     clk2,
    input  logic                     rstn,
    input  logic signed [DATA_W-1:0] din,
    input  logic [CW-1:0]            din_ch,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic signed [COEF_W-1:0] cin,
    input  logic [AW-1:0]            caddr,
    input  logic                     cload,
    input  logic                     flush,
    output logic signed [DATA_W-1:0] dout,
    output logic [CW-1:0]            dout_ch,
    output logic                     valid_out,
    output logic                     sat
);

    localparam int PW = DATA_W + COEF_W;
    localparam logic [ACC_W:0] RND_C = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_nxt;

    logic signed [COEF_W-1:0] coef [NUM_TAPS];
    logic signed [DATA_W-1:0] line [NUM_CH][NUM_TAPS];
    logic [AW-1:0]            wp   [NUM_CH];
    logic [AW-1:0]            k;
    logic [CW-1:0]            ch;
    logic signed [ACC_W-1:0]  acc;

    logic                     last_tap;
    logic [AW-1:0]            rd_idx;
    logic signed [COEF_W-1:0] coef_k;
    logic signed [DATA_W-1:0] samp_k;
    logic signed [PW-1:0]     coef_x, samp_x, prod;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W:0]    rnd, r;
    logic signed [DATA_W-1:0] dout_nxt;
    logic                     sat_nxt;

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_in  = 1'b0;
        valid_out = 1'b0;
        case (state)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) state_nxt = MAC;
            end
            MAC:     if (last_tap) state_nxt = OUT;
            OUT: begin
                valid_out = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // k = 0 reads the newest sample, stepping back through the circular line
    assign last_tap = (k == {AW{1'b1}});
    assign rd_idx   = wp[ch] - k;
    assign coef_k   = coef[k];
    assign samp_k   = line[ch][rd_idx];
    assign coef_x   = {{DATA_W{coef_k[COEF_W-1]}}, coef_k};
    assign samp_x   = {{COEF_W{samp_k[DATA_W-1]}}, samp_k};
    assign prod     = coef_x * samp_x;
    assign acc_nxt  = acc + {{AW{prod[PW-1]}}, prod};
    assign rnd      = $signed({acc_nxt[ACC_W-1], acc_nxt} + RND_C);
    assign r        = rnd >>> SHIFT;

    always_comb begin
        dout_nxt = r[DATA_W-1:0];
        sat_nxt  = 1'b0;
        if (r > MAX_V) begin
            dout_nxt = {1'b0, {(DATA_W-1){1'b1}}};
            sat_nxt  = 1'b1;
        end else if (r < MIN_V) begin
            dout_nxt = {1'b1, {(DATA_W-1){1'b0}}};
            sat_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < NUM_TAPS; t++) coef[t] <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wp[c] <= '0;
                for (int t = 0; t < NUM_TAPS; t++) line[c][t] <= '0;
            end
            k       <= '0;
            ch      <= '0;
            acc     <= '0;
            dout    <= '0;
            dout_ch <= '0;
            sat     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cload) coef[caddr] <= cin;
                    if (flush) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            wp[c] <= '0;
                            for (int t = 0; t < NUM_TAPS; t++) line[c][t] <= '0;
                        end
                    end
                    // the sample write lands after the flush clear when both occur
                    if (valid_in) begin
                        line[din_ch][flush ? {AW{1'b0}} : wp[din_ch]] <= din;
                        ch  <= din_ch;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= k + 1'b1;
                    if (last_tap) begin
                        wp[ch]  <= wp[ch] + 1'b1;
                        dout    <= dout_nxt;
                        sat     <= sat_nxt;
                        dout_ch <= ch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_mc.sv
// Bench for fir_mac_mc: reference model of y = sum coef[k]*x[n-k] per channel, checked
// every cycle on two instances (default and small SHIFT), plus directed literal cases.
module tb_fir_mac_mc;
    localparam int DATA_W = 16, COEF_W = 16, NUM_TAPS = 64, NUM_CH = 2;
    localparam int SHIFT = 21, SHIFT_B = 6;
    localparam int AW = 6, CW = 1;

    logic                     clk2 = 1'b0;
    logic                     rstn = 1'b0;
    logic signed [DATA_W-1:0] din = '0;
    logic [CW-1:0]            din_ch = '0;
    logic                     valid_in = 1'b0;
    logic signed [COEF_W-1:0] cin = '0;
    logic [AW-1:0]            caddr = '0;
    logic                     cload = 1'b0;
    logic                     flush = 1'b0;
    logic                     ready_in, valid_out, sat;
    logic signed [DATA_W-1:0] dout;
    logic [CW-1:0]            dout_ch;
    logic                     ready_b, valid_b, sat_b;
    logic signed [DATA_W-1:0] dout_b;
    logic [CW-1:0]            dout_ch_b;

    int checks = 0;
    int errors = 0;

    always #5 clk2 = ~clk2;

    fir_mac_mc #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS),
                 .NUM_CH(NUM_CH), .SHIFT(SHIFT)) u_dut (
        .clk2(clk2), .rstn(rstn), .din(din), .din_ch(din_ch), .valid_in(valid_in),
        .ready_in(ready_in), .cin(cin), .caddr(caddr), .cload(cload), .flush(flush),
        .dout(dout), .dout_ch(dout_ch), .valid_out(valid_out), .sat(sat));

    fir_mac_mc #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS),
                 .NUM_CH(NUM_CH), .SHIFT(SHIFT_B)) u_dut_b (
        .clk2(clk2), .rstn(rstn), .din(din), .din_ch(din_ch), .valid_in(valid_in),
        .ready_in(ready_b), .cin(cin), .caddr(caddr), .cload(cload), .flush(flush),
        .dout(dout_b), .dout_ch(dout_ch_b), .valid_out(valid_b), .sat(sat_b));

    // ---------------- reference model ----------------
    typedef struct { longint acc; int ch; int due; } exp_t;
    exp_t   expq[$];
    longint coef_m [NUM_TAPS];
    longint hist_m [NUM_CH][NUM_TAPS];   // index 0 = newest sample of the channel
    int     cyc = 0;
    int     ready_edge = 0;

    function automatic void rnd_sat(input longint acc, input int sh, output int y, output bit s);
        longint r;
        r = (acc + (longint'(1) << (sh - 1))) >>> sh;
        if (r > 32767)       begin y = 32767;  s = 1'b1; end
        else if (r < -32768) begin y = -32768; s = 1'b1; end
        else                 begin y = int'(r); s = 1'b0; end
    endfunction

    task automatic model_step();
        exp_t e;
        cyc = cyc + 1;
        if (!rstn) begin
            foreach (coef_m[i]) coef_m[i] = 0;
            foreach (hist_m[c, t]) hist_m[c][t] = 0;
            expq.delete();
            ready_edge = 0;
        end else if (cyc >= ready_edge) begin
            if (flush) foreach (hist_m[c, t]) hist_m[c][t] = 0;
            if (cload) coef_m[caddr] = longint'(cin);
            if (valid_in) begin
                for (int t = NUM_TAPS - 1; t > 0; t--) hist_m[din_ch][t] = hist_m[din_ch][t-1];
                hist_m[din_ch][0] = longint'(din);
                e.acc = 0;
                for (int t = 0; t < NUM_TAPS; t++) e.acc += coef_m[t] * hist_m[din_ch][t];
                e.ch  = int'(din_ch);
                e.due = cyc + NUM_TAPS;
                expq.push_back(e);
                ready_edge = cyc + NUM_TAPS + 2;
            end
        end
    endtask

    initial forever begin
        @(posedge clk2);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    int last_a = 0, last_b = 0, last_ch = 0;
    bit last_sa = 1'b0, last_sb = 1'b0;

    task automatic compare_step();
        bit exp_v, exp_r;
        checks++;
        if (!rstn) begin
            last_a = 0; last_b = 0; last_ch = 0; last_sa = 1'b0; last_sb = 1'b0;
            if (ready_in !== 1'b1 || valid_out !== 1'b0 || dout !== 16'sd0 || dout_ch !== 1'b0 ||
                sat !== 1'b0 || valid_b !== 1'b0 || dout_b !== 16'sd0 || sat_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got ready=%0b valid=%0b dout=%0d ch=%0d sat=%0b dout_b=%0d sat_b=%0b want 1 0 0 0 0 0 0",
                         ready_in, valid_out, dout, dout_ch, sat, dout_b, sat_b);
            end
            return;
        end
        exp_v = (expq.size() > 0) && (expq[0].due == cyc);
        exp_r = (cyc + 1 >= ready_edge);
        if (exp_v) begin
            rnd_sat(expq[0].acc, SHIFT, last_a, last_sa);
            rnd_sat(expq[0].acc, SHIFT_B, last_b, last_sb);
            last_ch = expq[0].ch;
            void'(expq.pop_front());
        end else if (expq.size() > 0 && expq[0].due < cyc) begin
            void'(expq.pop_front());
        end
        if (valid_out !== exp_v || valid_b !== exp_v || ready_in !== exp_r || ready_b !== exp_r ||
            int'(dout) != last_a || sat !== last_sa || int'(dout_ch) != last_ch ||
            int'(dout_b) != last_b || sat_b !== last_sb || int'(dout_ch_b) != last_ch) begin
            errors++;
            $display("FAIL model_cycle %0d got v=%0b r=%0b dout=%0d sat=%0b ch=%0d vb=%0b rb=%0b dout_b=%0d sat_b=%0b want v=%0b r=%0b dout=%0d sat=%0b ch=%0d dout_b=%0d sat_b=%0b",
                     cyc, valid_out, ready_in, dout, sat, dout_ch, valid_b, ready_b, dout_b, sat_b,
                     exp_v, exp_r, last_a, last_sa, last_ch, last_b, last_sb);
        end
    endtask

    initial forever begin
        @(negedge clk2);
        compare_step();
    end

    // ---------------- directed helpers ----------------
    int o_a, o_b, o_ch, o_lat;
    bit o_sa, o_sb;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready_in !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (ready_in !== 1'b1) chk("ready_timeout", longint'(ready_in), 1);
    endtask

    task automatic send(input int ch, input logic signed [15:0] d);
        wait_ready();
        din      = d;
        din_ch   = CW'(ch);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        cload    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic get_out();
        o_lat = 0; o_a = -99999; o_b = -99999; o_ch = -1; o_sa = 1'b0; o_sb = 1'b0;
        while (o_lat < NUM_TAPS + 10) begin
            @(negedge clk2);
            o_lat++;
            if (valid_out === 1'b1) begin
                o_a = int'(dout); o_sa = sat; o_ch = int'(dout_ch);
                o_b = int'(dout_b); o_sb = sat_b;
                break;
            end
        end
        if (o_ch < 0) chk("output_timeout", o_lat, NUM_TAPS + 1);
        tick();
    endtask

    task automatic load_all(input logic signed [15:0] v);
        for (int t = 0; t < NUM_TAPS; t++) begin
            wait_ready();
            cload = 1'b1;
            caddr = AW'(t);
            cin   = v;
            tick();
            cload = 1'b0;
        end
    endtask

    task automatic do_flush();
        wait_ready();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, seen, n;
        repeat (3) tick();
        @(negedge clk2);
        chk("reset_ready", longint'(ready_in), 1);
        chk("reset_valid", longint'(valid_out), 0);
        chk("reset_dout", longint'(dout), 0);
        chk("reset_sat", longint'(sat), 0);
        tick();
        rstn = 1'b1;
        tick();

        // zero input with flat coefficients, latency
        load_all(16'sh0100);
        send(0, 16'sh0000); get_out();
        chk("zero_dout", o_a, 0);
        chk("zero_sat", o_sa, 0);
        chk("zero_ch", o_ch, 0);
        chk("latency", o_lat, NUM_TAPS + 1);

        // impulse travels through the whole line then wraps out
        do_flush();
        send(0, 16'sh1000); get_out();
        chk("impulse", o_a, 1);
        chk("impulse_b", o_b, 16384);
        for (int i = 1; i < NUM_TAPS; i++) begin
            send(0, 16'sh0000); get_out();
            chk("impulse_tail", o_a, 1);
        end
        send(0, 16'sh0000); get_out();
        chk("impulse_gone", o_a, 0);

        // interleaved channels, no crosstalk
        do_flush();
        for (int i = 1; i <= 70; i++) begin
            send(0, 16'sh1000); get_out();
            if (i == 64 || i == 70) chk("ch0_settled", o_a, 32);
            send(1, 16'sh0000); get_out();
            chk("ch1_quiet", o_a, 0);
            if (i == 1) chk("ch1_tag", o_ch, 1);
        end

        // full-scale positive: clips on the last sample
        load_all(16'sh8000);
        do_flush();
        for (int i = 1; i <= NUM_TAPS; i++) begin
            send(0, 16'sh8000); get_out();
            if (i == 1) chk("fs_first", o_a, 512);
        end
        chk("pos_sat_dout", o_a, 32767);
        chk("pos_sat_flag", o_sa, 1);

        // full-scale negative: just inside range at SHIFT, clipped at small shift
        load_all(16'sh7fff);
        do_flush();
        for (int i = 1; i <= NUM_TAPS; i++) begin
            send(0, 16'sh8000); get_out();
        end
        chk("neg_edge_dout", o_a, -32767);
        chk("neg_edge_sat", o_sa, 0);
        chk("neg_sat_dout_b", o_b, -32768);
        chk("neg_sat_flag_b", o_sb, 1);

        // sample and coefficient write during MAC are dropped
        load_all(16'sh0100);
        do_flush();
        send(1, 16'sh1000);
        lo = 0; seen = -99999;
        while (ready_in !== 1'b1 && lo < 200) begin
            if (valid_out === 1'b1) seen = int'(dout);
            if (lo == 10) begin
                valid_in = 1'b1; din = 16'sh7fff; din_ch = 1'b1;
                cload = 1'b1; caddr = '0; cin = 16'sh7fff;
            end
            if (lo == 14) begin valid_in = 1'b0; cload = 1'b0; end
            tick();
            lo++;
        end
        chk("busy_cycles", lo, NUM_TAPS + 1);
        chk("busy_result", seen, 1);
        send(1, 16'sh1000); get_out();
        chk("coef_unchanged", o_a, 1);

        // reset in the middle of MAC
        send(0, 16'sh1000);
        repeat (10) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        seen = 0;
        repeat (NUM_TAPS + 5) begin
            if (valid_out === 1'b1) seen = 1;
            tick();
        end
        chk("no_strobe_after_reset", seen, 0);
        chk("dout_after_reset", longint'(dout), 0);
        send(0, 16'sh1000); get_out();
        chk("zeroed_coefs", o_a, 0);
        load_all(16'sh0100);
        send(1, 16'sh0000); get_out();
        chk("history_cleared", o_a, 0);

        // randomized traffic, including ignored strobes while busy
        for (int t = 0; t < NUM_TAPS; t++) begin
            wait_ready();
            cload = 1'b1; caddr = AW'(t); cin = 16'($urandom);
            tick();
            cload = 1'b0;
        end
        for (int i = 0; i < 120; i++) begin
            n = 0;
            while (ready_in !== 1'b1 && n < 300) begin
                valid_in = 1'($urandom);
                cload    = 1'($urandom);
                flush    = ($urandom_range(0, 7) == 0);
                caddr    = AW'($urandom);
                cin      = 16'($urandom);
                din      = 16'($urandom);
                din_ch   = CW'($urandom);
                tick();
                n++;
            end
            if (ready_in !== 1'b1) chk("rand_ready_timeout", longint'(ready_in), 1);
            flush    = ($urandom_range(0, 15) == 0);
            cload    = ($urandom_range(0, 3) == 0);
            caddr    = AW'($urandom);
            cin      = 16'($urandom);
            valid_in = ($urandom_range(0, 7) != 0);
            din      = 16'($urandom);
            din_ch   = CW'($urandom);
            tick();
            valid_in = 1'b0; cload = 1'b0; flush = 1'b0;
        end
        repeat (NUM_TAPS + 5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
